// File: rtl/intc_pkg.sv
// Shared definitions for the Minisys-1A external interrupt controller.
package intc_pkg;

   localparam int unsigned MAX_IRQ = 8;
   localparam int unsigned ID_W    = 3;

   // Memory-mapped register selects
   localparam logic [1:0] REG_MASK    = 2'd0;
   localparam logic [1:0] REG_PENDING = 2'd1;
   localparam logic [1:0] REG_INSVC   = 2'd2;
   localparam logic [1:0] REG_ID      = 2'd3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } intc_state_e;

   // Index of the lowest set bit; 0 when the vector is empty.
   function automatic logic [ID_W-1:0] lowest_set(input logic [MAX_IRQ-1:0] vec);
      logic [ID_W-1:0] idx;
      idx = '0;
      // Scan downwards so the lowest set bit is the last one written
      for (int i = MAX_IRQ - 1; i >= 0; i--) begin
         if (vec[i]) idx = ID_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Per-line 2-flop synchroniser followed by a rising-edge detector.
module irq_sync_edge #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] irq_i,
   output logic [WIDTH-1:0] edge_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;
   logic [WIDTH-1:0] sync_dly_q;

   // Synchroniser chain plus one delayed copy for edge detection
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q     <= '0;
         sync_q     <= '0;
         sync_dly_q <= '0;
      end else begin
         meta_q     <= irq_i;
         sync_q     <= meta_q;
         sync_dly_q <= sync_q;
      end
   end

   // A level held high produces a single one-cycle pulse
   assign edge_o = sync_q & ~sync_dly_q;

endmodule

// File: rtl/interrupt_controller.sv
// Prioritised external interrupt request generator for CP0 with MMIO mask/pending state.
module interrupt_controller
   import intc_pkg::*;
#(
   parameter int unsigned NUM_IRQ = 6
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [NUM_IRQ-1:0] irq_in,
   input  logic               int_ack,
   input  logic               eret,
   input  logic [1:0]         reg_sel,
   input  logic               reg_wen,
   input  logic [7:0]         reg_wdata,
   output logic [7:0]         reg_rdata,
   output logic               ExternalInterrupt,
   output logic [2:0]         int_id
);

   intc_state_e        state_q;
   logic               ext_q;
   logic [ID_W-1:0]    id_q;
   logic [NUM_IRQ-1:0] mask_q, mask_d;
   logic [NUM_IRQ-1:0] pend_q, pend_d;
   logic [NUM_IRQ-1:0] insvc_q;
   logic [NUM_IRQ-1:0] edge_det;
   logic [NUM_IRQ-1:0] eligible;
   logic [NUM_IRQ-1:0] sw_clr;
   logic [NUM_IRQ-1:0] ack_oh;
   logic [ID_W-1:0]    winner;
   logic               ack_fire;
   logic               unused_wdata;

   // Upper write-data bits are don't-care when fewer than 8 lines exist
   assign unused_wdata = ^reg_wdata;

   irq_sync_edge #(
      .WIDTH (NUM_IRQ)
   ) u_sync_edge (
      .clk_i  (clock),
      .rst_i  (reset),
      .irq_i  (irq_in),
      .edge_o (edge_det)
   );

   assign eligible = pend_q & mask_q;
   assign winner   = lowest_set(MAX_IRQ'(eligible));
   assign ack_fire = int_ack && (state_q == REQ);
   assign ack_oh   = ack_fire ? (NUM_IRQ'(1) << id_q) : '0;

   // Software writes and PENDING bookkeeping; a new edge beats any clear
   always_comb begin
      mask_d = mask_q;
      sw_clr = '0;
      if (reg_wen) begin
         case (reg_sel)
            REG_MASK:    mask_d = reg_wdata[NUM_IRQ-1:0];
            REG_PENDING: sw_clr = reg_wdata[NUM_IRQ-1:0];
            default:     ;
         endcase
      end
      pend_d = (pend_q & ~(sw_clr | ack_oh)) | edge_det;
   end

   // Mask and pending registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mask_q <= '0;
         pend_q <= '0;
      end else begin
         mask_q <= mask_d;
         pend_q <= pend_d;
      end
   end

   // Request FSM with registered request, source id and in-service state
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         ext_q   <= 1'b0;
         id_q    <= '0;
         insvc_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (eligible != '0) begin
                  id_q    <= winner;
                  ext_q   <= 1'b1;
                  state_q <= REQ;
               end
            end
            REQ: begin
               if (ack_fire) begin
                  insvc_q <= ack_oh;
                  ext_q   <= 1'b0;
                  state_q <= SERVICE;
               end else if (eligible == '0) begin
                  // Source masked or cleared by software before CP0 took it
                  ext_q   <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  id_q <= winner;
               end
            end
            SERVICE: begin
               if (eret) begin
                  insvc_q <= '0;
                  state_q <= IDLE;
               end
            end
            default: begin
               ext_q   <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Register read mux, zero-padded to the 8-bit bus
   always_comb begin
      reg_rdata = '0;
      case (reg_sel)
         REG_MASK:    reg_rdata[NUM_IRQ-1:0] = mask_q;
         REG_PENDING: reg_rdata[NUM_IRQ-1:0] = pend_q;
         REG_INSVC:   reg_rdata[NUM_IRQ-1:0] = insvc_q;
         default:     reg_rdata = {5'b0, id_q};
      endcase
   end

   assign ExternalInterrupt = ext_q;
   assign int_id            = id_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_interrupt_controller;

   localparam int N = 6;

   logic         clock = 1'b0;
   logic         reset;
   logic [N-1:0] irq_in;
   logic         int_ack;
   logic         eret;
   logic [1:0]   reg_sel;
   logic         reg_wen;
   logic [7:0]   reg_wdata;
   logic [7:0]   reg_rdata;
   logic         ExternalInterrupt;
   logic [2:0]   int_id;

   always #5 clock = ~clock;

   interrupt_controller #(
      .NUM_IRQ (N)
   ) dut (
      .clock             (clock),
      .reset             (reset),
      .irq_in            (irq_in),
      .int_ack           (int_ack),
      .eret              (eret),
      .reg_sel           (reg_sel),
      .reg_wen           (reg_wen),
      .reg_wdata         (reg_wdata),
      .reg_rdata         (reg_rdata),
      .ExternalInterrupt (ExternalInterrupt),
      .int_id            (int_id)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state: mode 0 idle, 1 requesting, 2 in service
   logic [N-1:0] m_mask, m_pend, m_insvc;
   int           m_mode;
   logic         m_ext;
   logic [2:0]   m_id;
   logic [N-1:0] hist [4];  // input samples at the last four edges, [0] newest

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [2:0] lowest(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return 3'(i);
      return 3'd0;
   endfunction

   function automatic void model_reset();
      m_mask = '0; m_pend = '0; m_insvc = '0;
      m_mode = 0; m_ext = 1'b0; m_id = '0;
      for (int k = 0; k < 4; k++) hist[k] = '0;
   endfunction

   function automatic void model_step();
      logic [N-1:0] elig, clr, edges;
      elig = m_pend & m_mask;
      for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = irq_in;
      // Line sampled high two edges ago, low three edges ago -> pending now
      edges = hist[2] & ~hist[3];
      clr = (reg_wen && reg_sel == 2'd1) ? reg_wdata[N-1:0] : '0;
      if (m_mode == 1 && int_ack) clr[m_id] = 1'b1;
      m_pend = (m_pend & ~clr) | edges;
      if (reg_wen && reg_sel == 2'd0) m_mask = reg_wdata[N-1:0];
      case (m_mode)
         0: if (elig != '0) begin m_mode = 1; m_id = lowest(elig); end
         1: begin
            if (int_ack) begin
               m_insvc = '0; m_insvc[m_id] = 1'b1; m_mode = 2;
            end else if (elig == '0) m_mode = 0;
            else m_id = lowest(elig);
         end
         default: if (eret) begin m_insvc = '0; m_mode = 0; end
      endcase
      m_ext = (m_mode == 1);
   endfunction

   function automatic logic [7:0] exp_rdata();
      case (reg_sel)
         2'd0:    return 8'(m_mask);
         2'd1:    return 8'(m_pend);
         2'd2:    return 8'(m_insvc);
         default: return {5'b0, m_id};
      endcase
   endfunction

   // One clock: advance the model at the edge, compare outputs on the falling edge
   task automatic cycle();
      @(posedge clock);
      if (reset) model_reset();
      else model_step();
      @(negedge clock);
      check_eq("ext", 32'(ExternalInterrupt), 32'(m_ext));
      check_eq("int_id", 32'(int_id), 32'(m_id));
      check_eq("rdata", 32'(reg_rdata), 32'(exp_rdata()));
   endtask

   task automatic set_reg(input logic [1:0] sel, input logic [7:0] data);
      reg_wen = 1'b1; reg_sel = sel; reg_wdata = data;
      cycle();
      reg_wen = 1'b0;
   endtask

   task automatic read_reg(input logic [1:0] sel, input logic [7:0] exp, input string tag);
      reg_sel = sel;
      #1;
      check_eq(tag, 32'(reg_rdata), 32'(exp));
   endtask

   task automatic pulse_ack();
      int_ack = 1'b1; cycle(); int_ack = 1'b0;
   endtask

   task automatic pulse_eret();
      eret = 1'b1; cycle(); eret = 1'b0;
   endtask

   initial begin
      reset = 1'b1; irq_in = '0; int_ack = 1'b0; eret = 1'b0;
      reg_sel = 2'd0; reg_wen = 1'b0; reg_wdata = '0;
      model_reset();
      cycle(); cycle();
      check_eq("rst_ext", 32'(ExternalInterrupt), 0);
      check_eq("rst_id", 32'(int_id), 0);
      check_eq("rst_rdata", 32'(reg_rdata), 0);
      reset = 1'b0;
      cycle();

      // Single source, 4-cycle request latency, ack and eret
      set_reg(2'd0, 8'h04);
      irq_in = 6'b000100;
      repeat (3) begin
         cycle();
         check_eq("lat_early", 32'(ExternalInterrupt), 0);
      end
      cycle();
      check_eq("lat4_ext", 32'(ExternalInterrupt), 1);
      check_eq("lat4_id", 32'(int_id), 2);
      irq_in = '0;
      pulse_ack();
      check_eq("ack_ext", 32'(ExternalInterrupt), 0);
      read_reg(2'd2, 8'h04, "ack_insvc");
      read_reg(2'd1, 8'h00, "ack_pend");
      pulse_eret();
      read_reg(2'd2, 8'h00, "eret_insvc");

      // Simultaneous sources: lowest index first, other follows after eret
      set_reg(2'd0, 8'h3F);
      irq_in = 6'b010010;
      repeat (4) cycle();
      irq_in = '0;
      check_eq("prio_id", 32'(int_id), 1);
      pulse_ack();
      pulse_eret();
      check_eq("post_eret_ext", 32'(ExternalInterrupt), 0);
      cycle();
      check_eq("second_ext", 32'(ExternalInterrupt), 1);
      check_eq("second_id", 32'(int_id), 4);
      pulse_ack();
      pulse_eret();

      // Withdraw by masking during REQ, then W1C the stranded pending bit
      irq_in = 6'b001000;
      repeat (4) cycle();
      irq_in = '0;
      check_eq("req3_id", 32'(int_id), 3);
      set_reg(2'd0, 8'h00);
      cycle();
      check_eq("withdraw_ext", 32'(ExternalInterrupt), 0);
      read_reg(2'd1, 8'h08, "withdraw_pend");
      set_reg(2'd1, 8'h08);
      read_reg(2'd1, 8'h00, "w1c_pend");

      // New edge while in service is held until eret
      set_reg(2'd0, 8'h3F);
      irq_in = 6'b100000;
      repeat (4) cycle();
      irq_in = '0;
      check_eq("svc_id", 32'(int_id), 5);
      pulse_ack();
      irq_in = 6'b000001;
      repeat (6) cycle();
      irq_in = '0;
      check_eq("svc_hold_ext", 32'(ExternalInterrupt), 0);
      read_reg(2'd1, 8'h01, "svc_pend");
      pulse_eret();
      check_eq("svc_eret_ext", 32'(ExternalInterrupt), 0);
      cycle();
      check_eq("svc_rereq_ext", 32'(ExternalInterrupt), 1);
      check_eq("svc_rereq_id", 32'(int_id), 0);
      pulse_ack();
      pulse_eret();

      // Edge and W1C on the same bit in the same cycle: set wins; eret in IDLE ignored
      set_reg(2'd0, 8'h00);
      irq_in = 6'b100000;
      cycle(); cycle();
      reg_wen = 1'b1; reg_sel = 2'd1; reg_wdata = 8'h20;
      cycle();
      reg_wen = 1'b0; irq_in = '0;
      read_reg(2'd1, 8'h20, "set_wins");
      pulse_eret();
      check_eq("idle_eret_ext", 32'(ExternalInterrupt), 0);
      read_reg(2'd2, 8'h00, "idle_eret_insvc");
      read_reg(2'd1, 8'h20, "idle_eret_pend");
      set_reg(2'd1, 8'h3F);

      // Random traffic against the model
      for (int n = 0; n < 3000; n++) begin
         for (int b = 0; b < N; b++) if ($urandom_range(7) == 0) irq_in[b] = ~irq_in[b];
         int_ack   = m_ext ? ($urandom_range(2) == 0) : ($urandom_range(15) == 0);
         eret      = ($urandom_range(7) == 0);
         reg_wen   = ($urandom_range(9) == 0);
         reg_sel   = 2'($urandom_range(3));
         reg_wdata = 8'($urandom);
         reset     = ($urandom_range(399) == 0);
         cycle();
      end
      int_ack = 1'b0; eret = 1'b0; reg_wen = 1'b0; reset = 1'b0; irq_in = '0;

      // Asynchronous reset while requesting
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      set_reg(2'd0, 8'h02);
      irq_in = 6'b000010;
      repeat (4) cycle();
      irq_in = '0;
      check_eq("pre_rst_ext", 32'(ExternalInterrupt), 1);
      reg_sel = 2'd0;
      reset = 1'b1;
      #1;
      check_eq("async_rst_ext", 32'(ExternalInterrupt), 0);
      check_eq("async_rst_id", 32'(int_id), 0);
      check_eq("async_rst_mask", 32'(reg_rdata), 0);
      cycle();
      reset = 1'b0;
      read_reg(2'd1, 8'h00, "rst_pend");
      read_reg(2'd2, 8'h00, "rst_insvc");
      cycle(); cycle();
      check_eq("rst_idle_ext", 32'(ExternalInterrupt), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
